pheap_param: RTL and testbench
==============================

// Module: pheap_param
// PURPOSE
//  Parametrised register-array binary-heap priority queue; successor to the fixed 32-bit LEQ/DEQ pheap.
//  Adds configurable priority/tag width, depth and min/max ordering, plus an atomic REPLACE op, flush, and count/full/empty/err status.
//  Sits between a producer issuing valid/op requests and a consumer taking valid_out results.
//  One sift-up or sift-down heap level per clock.
// PARAMETERS
//  PRI_W      32   priority field width (unsigned)
//  TAG_W      8    payload tag carried with each priority
//  DEPTH      15   max entries, >=2; CNT_W = $clog2(DEPTH+1)
//  MIN_FIRST  1    1: smallest priority served first; 0: largest first
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  valid      in   1      request strobe; accepted when valid && rdy
//  op         in   2      00 NOP, 01 ENQ, 10 DEQ, 11 RPL (dequeue root + enqueue input, atomic)
//  pri_in     in   PRI_W  priority for ENQ/RPL
//  tag_in     in   TAG_W  tag for ENQ/RPL
//  flush      in   1      empties queue when sampled with rdy=1; has priority over valid
//  rdy        out  1      1 iff FSM in IDLE (combinational from state)
//  valid_out  out  1      one-cycle pulse: pri_out/tag_out hold a dequeued entry
//  pri_out    out  PRI_W  dequeued priority, held until next dequeue
//  tag_out    out  TAG_W  dequeued tag, held until next dequeue
//  count      out  CNT_W  entries currently stored
//  full       out  1      count == DEPTH
//  empty      out  1      count == 0
//  err        out  1      one-cycle pulse: rejected op (ENQ when full, DEQ/RPL when empty)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, count 0, valid_out 0, pri_out 0, tag_out 0, err 0; heap contents don't-care.
//   Reset mid-sift aborts the operation; all entries are lost.
//  better(a,b): MIN_FIRST ? a.pri < b.pri : a.pri > b.pri; strict, so ties never swap. Tags are never compared.
//  FSM states: IDLE, UP, DOWN. rdy = (state==IDLE). A request is accepted on a rising edge with valid&&rdy&&!flush.
//  Flush: if flush&&rdy: count<=0 next edge; valid ignored; no err, no valid_out.
//  ENQ, not full: heap[count]<={pri_in,tag_in}; count++; cur<=old count; -> UP.
//  ENQ, full: dropped; err=1 next cycle; stay IDLE.
//  UP: p=(cur-1)/2. If cur==0 or !better(heap[cur],heap[p]) -> IDLE. Else swap heap[cur]/heap[p], cur<=p, stay in UP.
//  DEQ, not empty, on the accept edge:
//   {pri_out,tag_out}<=heap[0]; valid_out=1 for the next cycle only.
//   heap[0]<=heap[count-1]; count--; cur<=0.
//   Then -> DOWN if the new count >=2, else -> IDLE.
//  DEQ, empty: err pulse; valid_out stays 0; pri_out/tag_out unchanged.
//  RPL, not empty: {pri_out,tag_out}<=heap[0]; valid_out pulse; heap[0]<=input; count unchanged.
//   Then -> DOWN if count >=2, else -> IDLE.
//  RPL, empty: err pulse; input dropped.
//  DOWN: l=2cur+1, r=2cur+2; only indices < count are valid children.
//   Best child c: r if r valid && better(heap[r],heap[l]), else l (left wins ties).
//   If no valid child or !better(heap[c],heap[cur]) -> IDLE. Else swap, cur<=c, stay in DOWN.
//  Latency: rdy low for at most L=ceil(log2(DEPTH+1)) cycles after any accept.
//   valid_out asserts exactly 1 cycle after a DEQ/RPL accept.
//  count/full/empty update on the accept edge. NOP accepts and does nothing. Op/data are don't-care while rdy=0.
//  Arithmetic: index math at CNT_W bits; never index >= DEPTH.
// TESTING
//  1 Reset: ENQ 4 values, assert rst_n=0 during UP -> count=0, empty=1, rdy=1, valid_out=0 immediately.
//  2 MIN_FIRST=1: ENQ 5,3,9,1 then 4 DEQ -> pri_out 1,3,5,9.
//     Each valid_out 1 cycle after accept; empty=1 after the last.
//  3 Fill 15 entries (DEPTH=15) -> full=1. 16th ENQ -> err pulse, count stays 15. Then DEQ returns the min.
//  4 DEQ and RPL on empty -> err pulse each, valid_out=0, count=0.
//  5 Heap {2,7,8}, RPL pri 10 -> pri_out 2, count 3. Next DEQs -> 7,8,10.
//  6 MIN_FIRST=0: ENQ 5,3,9 (tags A,B,C) -> DEQ gives 9/C, 5/A, 3/B.
//     Then flush with 2 entries stored -> count=0 next cycle, no valid_out.

Source files
------------

// File: rtl/pheap_param.sv
// Parametrised binary-heap priority queue held in a register array.
// Moves one heap level per clock while sifting up after ENQ or down after DEQ/RPL.
module pheap_param #(
    parameter int PRI_W     = 32,
    parameter int TAG_W     = 8,
    parameter int DEPTH     = 15,
    parameter int MIN_FIRST = 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [1:0]       op,
    input  logic [PRI_W-1:0] pri_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             rdy,
    output logic             valid_out,
    output logic [PRI_W-1:0] pri_out,
    output logic [TAG_W-1:0] tag_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam logic [1:0] OP_ENQ = 2'b01;
    localparam logic [1:0] OP_DEQ = 2'b10;
    localparam logic [1:0] OP_RPL = 2'b11;

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cur;
    logic [PRI_W-1:0] pri_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [CNT_W-1:0] p_idx, l_sel, r_sel, c_idx, last_idx;
    logic [CNT_W:0]   l_idx, r_idx;
    logic             l_valid, r_valid, up_swap, down_swap;
    logic             take, enq_ok, deq_ok, rpl_ok, reject;

    // Strict comparison so equal priorities never swap.
    function automatic logic better(input logic [PRI_W-1:0] a, input logic [PRI_W-1:0] b);
        if (MIN_FIRST != 0) return a < b;
        else                return a > b;
    endfunction

    assign rdy   = (state == IDLE);
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign take     = rdy && valid && !flush;
    assign enq_ok   = take && (op == OP_ENQ) && !full;
    assign deq_ok   = take && (op == OP_DEQ) && !empty;
    assign rpl_ok   = take && (op == OP_RPL) && !empty;
    assign reject   = take && (((op == OP_ENQ) && full) ||
                               (((op == OP_DEQ) || (op == OP_RPL)) && empty));
    assign last_idx = count - CNT_W'(1);

    // Children are computed one bit wider so 2*cur+2 cannot wrap; invalid children read slot 0.
    always_comb begin
        p_idx     = (cur - CNT_W'(1)) >> 1;
        l_idx     = {cur, 1'b1};
        r_idx     = l_idx + (CNT_W + 1)'(1);
        l_valid   = l_idx < {1'b0, count};
        r_valid   = r_idx < {1'b0, count};
        l_sel     = l_valid ? l_idx[CNT_W-1:0] : '0;
        r_sel     = r_valid ? r_idx[CNT_W-1:0] : '0;
        c_idx     = (r_valid && better(pri_mem[r_sel], pri_mem[l_sel])) ? r_sel : l_sel;
        up_swap   = (state == UP) && (cur != '0) && better(pri_mem[cur], pri_mem[p_idx]);
        down_swap = (state == DOWN) && l_valid && better(pri_mem[c_idx], pri_mem[cur]);
    end

    always_ff @(posedge clk) begin
        if (enq_ok) begin
            pri_mem[count] <= pri_in;
            tag_mem[count] <= tag_in;
        end else if (deq_ok) begin
            pri_mem[0] <= pri_mem[last_idx];
            tag_mem[0] <= tag_mem[last_idx];
        end else if (rpl_ok) begin
            pri_mem[0] <= pri_in;
            tag_mem[0] <= tag_in;
        end else if (up_swap) begin
            pri_mem[cur]   <= pri_mem[p_idx];
            tag_mem[cur]   <= tag_mem[p_idx];
            pri_mem[p_idx] <= pri_mem[cur];
            tag_mem[p_idx] <= tag_mem[cur];
        end else if (down_swap) begin
            pri_mem[cur]   <= pri_mem[c_idx];
            tag_mem[cur]   <= tag_mem[c_idx];
            pri_mem[c_idx] <= pri_mem[cur];
            tag_mem[c_idx] <= tag_mem[cur];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            cur       <= '0;
            valid_out <= 1'b0;
            pri_out   <= '0;
            tag_out   <= '0;
            err       <= 1'b0;
        end else begin
            valid_out <= deq_ok || rpl_ok;
            err       <= reject;
            if (deq_ok || rpl_ok) begin
                pri_out <= pri_mem[0];
                tag_out <= tag_mem[0];
            end
            case (state)
                IDLE: begin
                    if (flush) begin
                        count <= '0;
                    end else if (enq_ok) begin
                        count <= count + CNT_W'(1);
                        cur   <= count;
                        state <= UP;
                    end else if (deq_ok) begin
                        count <= last_idx;
                        cur   <= '0;
                        state <= (count >= CNT_W'(3)) ? DOWN : IDLE;
                    end else if (rpl_ok) begin
                        cur   <= '0;
                        state <= (count >= CNT_W'(2)) ? DOWN : IDLE;
                    end
                end
                UP: begin
                    if (up_swap) cur <= p_idx;
                    else         state <= IDLE;
                end
                DOWN: begin
                    if (down_swap) cur <= c_idx;
                    else           state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pheap_param.sv
// Drives a min-first and a max-first heap with identical requests and checks both
// against queue-based models that simply pick the best entry by scanning.
module tb_pheap_param;

    localparam int PRI_W = 32;
    localparam int TAG_W = 8;
    localparam int DEPTH = 15;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int L     = $clog2(DEPTH + 1);

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] ENQ = 2'b01;
    localparam logic [1:0] DEQ = 2'b10;
    localparam logic [1:0] RPL = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             valid, flush;
    logic [1:0]       op;
    logic [PRI_W-1:0] pri_in;
    logic [TAG_W-1:0] tag_in;

    logic [1:0]       rdy_s, valid_out_s, full_s, empty_s, err_s;
    logic [PRI_W-1:0] pri_out_s [2];
    logic [TAG_W-1:0] tag_out_s [2];
    logic [CNT_W-1:0] count_s   [2];

    pheap_param #(.PRI_W(PRI_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .MIN_FIRST(1)) dut_min (
        .clk(clk), .rst_n(rst_n), .valid(valid), .op(op), .pri_in(pri_in), .tag_in(tag_in),
        .flush(flush), .rdy(rdy_s[0]), .valid_out(valid_out_s[0]), .pri_out(pri_out_s[0]),
        .tag_out(tag_out_s[0]), .count(count_s[0]), .full(full_s[0]), .empty(empty_s[0]),
        .err(err_s[0]));

    pheap_param #(.PRI_W(PRI_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .MIN_FIRST(0)) dut_max (
        .clk(clk), .rst_n(rst_n), .valid(valid), .op(op), .pri_in(pri_in), .tag_in(tag_in),
        .flush(flush), .rdy(rdy_s[1]), .valid_out(valid_out_s[1]), .pri_out(pri_out_s[1]),
        .tag_out(tag_out_s[1]), .count(count_s[1]), .full(full_s[1]), .empty(empty_s[1]),
        .err(err_s[1]));

    typedef struct {
        logic [PRI_W-1:0] pri;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t             q_min[$];
    ent_t             q_max[$];
    logic [PRI_W-1:0] last_pri [2];
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int best_index(input ent_t q[$], input bit min_first);
        int b = 0;
        for (int i = 1; i < q.size(); i++)
            if (min_first ? (q[i].pri < q[b].pri) : (q[i].pri > q[b].pri)) b = i;
        return b;
    endfunction

    // Model update and output check for one instance, sampled the cycle after the accept edge.
    task automatic model_check(input int m, input logic [1:0] o, input logic f,
                               input logic [PRI_W-1:0] p, input logic [TAG_W-1:0] t);
        ent_t  q[$];
        ent_t  e;
        int    b, hit;
        bit    exp_err, exp_vo;
        string s;
        exp_err = 1'b0;
        exp_vo  = 1'b0;
        e.pri   = p;
        e.tag   = t;
        if (m == 0) begin q = q_min; s = "min"; end
        else        begin q = q_max; s = "max"; end
        if (f) begin
            q.delete();
        end else begin
            case (o)
                ENQ: if (q.size() == DEPTH) exp_err = 1'b1; else q.push_back(e);
                DEQ, RPL: begin
                    if (q.size() == 0) begin
                        exp_err = 1'b1;
                    end else begin
                        exp_vo = 1'b1;
                        b = best_index(q, m == 0);
                        last_pri[m] = q[b].pri;
                        hit = -1;
                        for (int i = 0; i < q.size(); i++)
                            if (q[i].pri == q[b].pri && q[i].tag == tag_out_s[m]) hit = i;
                        checkOutput({s, " tag_among_best"}, 64'(hit >= 0), 64'(1));
                        q.delete(hit >= 0 ? hit : b);
                        if (o == RPL) q.push_back(e);
                    end
                end
                default: ;
            endcase
        end
        checkOutput({s, " err"},       64'(err_s[m]),       64'(exp_err));
        checkOutput({s, " valid_out"}, 64'(valid_out_s[m]), 64'(exp_vo));
        checkOutput({s, " pri_out"},   64'(pri_out_s[m]),   64'(last_pri[m]));
        checkOutput({s, " count"},     64'(count_s[m]),     64'(q.size()));
        checkOutput({s, " full"},      64'(full_s[m]),      64'(q.size() == DEPTH));
        checkOutput({s, " empty"},     64'(empty_s[m]),     64'(q.size() == 0));
        if (m == 0) q_min = q;
        else        q_max = q;
    endtask

    // Issues one request when both queues are ready, then waits for both to return to ready.
    task automatic applyStimulus(input logic [1:0] o, input logic f,
                                 input logic [PRI_W-1:0] p, input logic [TAG_W-1:0] t);
        int busy [2];
        int n;
        valid  = 1'b1;
        op     = o;
        flush  = f;
        pri_in = p;
        tag_in = t;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        flush = 1'b0;
        for (int m = 0; m < 2; m++) begin
            model_check(m, o, f, p, t);
            busy[m] = rdy_s[m] ? 0 : 1;
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            checkOutput("valid_out_pulse_end", 64'(valid_out_s[m]), 64'(0));
            checkOutput("err_pulse_end",       64'(err_s[m]),       64'(0));
            if (!rdy_s[m]) busy[m]++;
        end
        n = 0;
        while (rdy_s != 2'b11 && n < 40) begin
            @(negedge clk);
            n++;
            for (int m = 0; m < 2; m++) if (!rdy_s[m]) busy[m]++;
        end
        checkOutput("rdy_timeout", 64'(rdy_s == 2'b11), 64'(1));
        for (int m = 0; m < 2; m++) checkOutput("busy_cycles_le_L", 64'(busy[m] <= L), 64'(1));
    endtask

    task automatic check_reset_state();
        for (int m = 0; m < 2; m++) begin
            checkOutput("rst count",     64'(count_s[m]),     64'(0));
            checkOutput("rst empty",     64'(empty_s[m]),     64'(1));
            checkOutput("rst full",      64'(full_s[m]),      64'(0));
            checkOutput("rst rdy",       64'(rdy_s[m]),       64'(1));
            checkOutput("rst valid_out", 64'(valid_out_s[m]), 64'(0));
            checkOutput("rst err",       64'(err_s[m]),       64'(0));
            checkOutput("rst pri_out",   64'(pri_out_s[m]),   64'(0));
            checkOutput("rst tag_out",   64'(tag_out_s[m]),   64'(0));
        end
    endtask

    logic [PRI_W-1:0] p;
    logic [1:0]       o;
    logic             f;
    int               t2_min [4] = '{1, 3, 5, 9};
    int               t2_max [4] = '{9, 5, 3, 1};
    int               t5_min [3] = '{7, 8, 10};
    int               t6_tag [3] = '{8'hC, 8'hA, 8'hB};
    int               t6_pri [3] = '{9, 5, 3};

    initial begin
        valid       = 1'b0;
        flush       = 1'b0;
        op          = NOP;
        pri_in      = '0;
        tag_in      = '0;
        last_pri[0] = '0;
        last_pri[1] = '0;

        repeat (3) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while a sift-up is in progress.
        applyStimulus(ENQ, 1'b0, 32'd5, 8'h1);
        applyStimulus(ENQ, 1'b0, 32'd6, 8'h2);
        applyStimulus(ENQ, 1'b0, 32'd7, 8'h3);
        valid  = 1'b1;
        op     = ENQ;
        pri_in = 32'd1;
        tag_in = 8'h4;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        checkOutput("rdy_low_in_up", 64'(rdy_s), 64'(0));
        rst_n = 1'b0;
        #1;
        check_reset_state();
        q_min.delete();
        q_max.delete();
        last_pri[0] = '0;
        last_pri[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic ordering in both directions.
        applyStimulus(ENQ, 1'b0, 32'd5, 8'h0);
        applyStimulus(ENQ, 1'b0, 32'd3, 8'h1);
        applyStimulus(ENQ, 1'b0, 32'd9, 8'h2);
        applyStimulus(ENQ, 1'b0, 32'd1, 8'h3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(DEQ, 1'b0, '0, '0);
            checkOutput("t2 min order", 64'(pri_out_s[0]), 64'(t2_min[i]));
            checkOutput("t2 max order", 64'(pri_out_s[1]), 64'(t2_max[i]));
        end
        checkOutput("t2 empty", 64'(empty_s), 64'(2'b11));

        // Fill to capacity, overflow, then drain.
        for (int i = 0; i < DEPTH; i++) applyStimulus(ENQ, 1'b0, PRI_W'($urandom_range(0, 40)), TAG_W'(i));
        checkOutput("t3 full", 64'(full_s), 64'(2'b11));
        applyStimulus(ENQ, 1'b0, 32'd0, 8'hFF);
        for (int i = 0; i < DEPTH; i++) applyStimulus(DEQ, 1'b0, '0, '0);

        // Underflow on DEQ and RPL.
        applyStimulus(DEQ, 1'b0, '0, '0);
        applyStimulus(RPL, 1'b0, 32'd4, 8'h4);

        // Replace at the root.
        applyStimulus(ENQ, 1'b0, 32'd2, 8'h0);
        applyStimulus(ENQ, 1'b0, 32'd7, 8'h1);
        applyStimulus(ENQ, 1'b0, 32'd8, 8'h2);
        applyStimulus(RPL, 1'b0, 32'd10, 8'h3);
        checkOutput("t5 rpl pri", 64'(pri_out_s[0]), 64'(2));
        checkOutput("t5 rpl count", 64'(count_s[0]), 64'(3));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(DEQ, 1'b0, '0, '0);
            checkOutput("t5 min order", 64'(pri_out_s[0]), 64'(t5_min[i]));
        end

        // Tags travel with priorities; flush empties without output.
        applyStimulus(ENQ, 1'b0, 32'd5, 8'hA);
        applyStimulus(ENQ, 1'b0, 32'd3, 8'hB);
        applyStimulus(ENQ, 1'b0, 32'd9, 8'hC);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(DEQ, 1'b0, '0, '0);
            checkOutput("t6 max pri", 64'(pri_out_s[1]), 64'(t6_pri[i]));
            checkOutput("t6 max tag", 64'(tag_out_s[1]), 64'(t6_tag[i]));
        end
        applyStimulus(ENQ, 1'b0, 32'd4, 8'h1);
        applyStimulus(ENQ, 1'b0, 32'd6, 8'h2);
        applyStimulus(DEQ, 1'b1, '0, '0);

        // Random mix with frequent priority ties.
        for (int i = 0; i < 400; i++) begin
            o = 2'($urandom_range(0, 3));
            f = ($urandom_range(0, 24) == 0);
            p = ($urandom_range(0, 3) == 0) ? PRI_W'($urandom) : PRI_W'($urandom_range(0, 12));
            applyStimulus(o, f, p, TAG_W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
